// File: rtl/mapper_state_ctl.sv
// Hypervisor-side shadow of the four user mapper bytes: saved on trap entry, restored through
// the mapper load port on trap exit. Optional macro MAPSTATE_DIRTY_ONLY_EN restores only dirty bytes.
module mapper_state_ctl #(
    parameter bit         SAVE_ON_ENTER = 1'b1,
    parameter logic [2:0] STATUS_ADDR   = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trap_enter,
    input  logic       trap_exit,
    input  logic [7:0] map_reg_data,
    output logic [1:0] map_rd_sel,
    input  logic       mapper_busy,
    output logic       user_load,
    output logic [1:0] user_load_sel,
    output logic [7:0] user_load_data,
    input  logic       cpu_cs,
    input  logic       cpu_we,
    input  logic [2:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       busy,
    output logic       save_done,
    output logic       restore_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;
    logic [7:0] r_shadow      [4];
    logic [7:0] w_shadow_next [4];
    logic [3:0] r_dirty;
    logic [3:0] w_dirty_next;
    logic       r_overrun;
    logic       w_overrun_next;
    logic       r_save_done;
    logic       w_save_done_next;
    logic       r_restore_done;
    logic       w_restore_done_next;

    logic       w_idle;
    logic       w_cpu_wr;
    logic       w_last;
    logic [1:0] w_cnt_adv;

`ifdef MAPSTATE_DIRTY_ONLY_EN
    // Lowest dirty index at or above 'from'; bit 2 flags that one exists.
    function automatic logic [2:0] next_dirty(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from)))
                res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    logic [2:0] w_nd_entry;
    logic [2:0] w_nd_adv;
`endif

    assign w_idle   = (r_state == ST_IDLE);
    assign w_cpu_wr = cpu_cs && cpu_we && w_idle;
    assign busy     = !w_idle;

    // Successor byte during restore, and whether the current byte is the final one.
`ifdef MAPSTATE_DIRTY_ONLY_EN
    assign w_nd_adv  = next_dirty(r_dirty, {1'b0, r_cnt} + 3'd1);
    assign w_last    = !w_nd_adv[2];
    assign w_cnt_adv = w_nd_adv[1:0];
`else
    assign w_last    = (r_cnt == 2'd3);
    assign w_cnt_adv = r_cnt + 2'd1;
`endif

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_shadow_next       = r_shadow;
        w_dirty_next        = r_dirty;
        w_overrun_next      = r_overrun;
        w_save_done_next    = 1'b0;
        w_restore_done_next = 1'b0;
        map_rd_sel          = 2'd0;
        user_load           = 1'b0;
        user_load_sel       = 2'd0;
        user_load_data      = 8'h00;
`ifdef MAPSTATE_DIRTY_ONLY_EN
        w_nd_entry          = 3'b000;
`endif

        // CPU writes land first so a same-cycle trap sequence sees them.
        if (w_cpu_wr) begin
            if (cpu_addr == STATUS_ADDR) begin
                if (cpu_wdata[2])
                    w_overrun_next = 1'b0;
            end else if (cpu_addr < 3'd4) begin
                w_shadow_next[cpu_addr[1:0]] = cpu_wdata;
                w_dirty_next[cpu_addr[1:0]]  = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (trap_enter) begin
                    if (trap_exit)
                        w_overrun_next = 1'b1;
                    if (SAVE_ON_ENTER) begin
                        w_state_next = ST_SAVE;
                        w_cnt_next   = 2'd0;
                    end else begin
                        w_save_done_next = 1'b1;
                    end
                end else if (trap_exit) begin
`ifdef MAPSTATE_DIRTY_ONLY_EN
                    w_nd_entry = next_dirty(w_dirty_next, 3'd0);
                    if (w_nd_entry[2]) begin
                        w_state_next = ST_RESTORE;
                        w_cnt_next   = w_nd_entry[1:0];
                    end else begin
                        w_restore_done_next = 1'b1;
                        w_dirty_next        = 4'b0000;
                    end
`else
                    w_state_next = ST_RESTORE;
                    w_cnt_next   = 2'd0;
`endif
                end
            end

            ST_SAVE: begin
                map_rd_sel                = r_cnt;
                w_shadow_next[r_cnt]      = map_reg_data;
                w_dirty_next[r_cnt]       = 1'b0;
                if (trap_enter || trap_exit)
                    w_overrun_next = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_state_next     = ST_IDLE;
                    w_cnt_next       = 2'd0;
                    w_save_done_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end

            ST_RESTORE: begin
                if (trap_enter || trap_exit)
                    w_overrun_next = 1'b1;
                // Strobe is also gated by reset so nothing is loaded in the reset cycle.
                if (!mapper_busy && !reset) begin
                    user_load      = 1'b1;
                    user_load_sel  = r_cnt;
                    user_load_data = r_shadow[r_cnt];
                    if (w_last) begin
                        w_state_next        = ST_IDLE;
                        w_cnt_next          = 2'd0;
                        w_restore_done_next = 1'b1;
                        w_dirty_next        = 4'b0000;
                    end else begin
                        w_cnt_next = w_cnt_adv;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // NOTE: the shadow bytes are plain flops and are cleared by reset along with the rest of the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= 2'd0;
            r_dirty        <= 4'b0000;
            r_overrun      <= 1'b0;
            r_save_done    <= 1'b0;
            r_restore_done <= 1'b0;
            for (int i = 0; i < 4; i++)
                r_shadow[i] <= 8'h00;
        end else begin
            r_cnt          <= w_cnt_next;
            r_dirty        <= w_dirty_next;
            r_overrun      <= w_overrun_next;
            r_save_done    <= w_save_done_next;
            r_restore_done <= w_restore_done_next;
            for (int i = 0; i < 4; i++)
                r_shadow[i] <= w_shadow_next[i];
        end
    end

    assign save_done    = r_save_done;
    assign restore_done = r_restore_done;

    always_comb begin
        cpu_rdata = 8'h00;
        if (cpu_addr == STATUS_ADDR)
            cpu_rdata = {5'b00000, r_overrun, |r_dirty, busy};
        else if (cpu_addr < 3'd4)
            cpu_rdata = r_shadow[cpu_addr[1:0]];
    end

endmodule

// File: doc/mapper_state_ctl.md
Name: mapper_state_ctl

Overview:
Hypervisor-side controller that drives the user-mapper register port from the other end.
- On trap entry it reads the four user (set 0) mapper bytes into shadow registers.
- Hypervisor code can read and modify those shadows over a small CPU register window.
- On trap exit it writes the shadows back through the mapper's hypervisor load port (load select plus byte).
- Sits between the hypervisor trap logic, the hypervisor I/O decode and the 4510 mapper.

Parameters:
SAVE_ON_ENTER, 1, 1 = trap_enter runs the save sequence; 0 = trap_enter only pulses save_done.
STATUS_ADDR, 4, cpu_addr value that selects the status register.

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
trap_enter  in  1  1-cycle pulse, hypervisor trap taken
trap_exit  in  1  1-cycle pulse, hypervisor return
map_reg_data  in  8  user-mapper byte selected by map_rd_sel (combinational from mapper)
map_rd_sel  out  2  byte select to mapper readout (0=A,1=X,2=Y,3=Z layout)
mapper_busy  in  1  mapper MAP sequencer not idle; load port not accepting
user_load  out  1  hypervisor load strobe to mapper
user_load_sel  out  2  which byte (0..3) is loaded
user_load_data  out  8  byte value driven onto mapper data bus
cpu_cs  in  1  register window select
cpu_we  in  1  1 = write
cpu_addr  in  3  0..3 shadow bytes, STATUS_ADDR status
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data, combinational
busy  out  1  save or restore in progress
save_done  out  1  1-cycle pulse
restore_done  out  1  1-cycle pulse

Behaviour:
Reset:
- State IDLE; counter 0; shadows 0x00; dirty[3:0]=0; overrun=0.
- All strobes and outputs 0; map_rd_sel=0.

States: IDLE, SAVE, RESTORE, 2-bit counter cnt.

IDLE:
- trap_enter with SAVE_ON_ENTER=1 -> SAVE, cnt=0.
- trap_enter with SAVE_ON_ENTER=0 -> save_done next cycle, stay IDLE.
- trap_exit -> RESTORE, cnt=0.
- Both asserted same cycle: enter wins; exit dropped; overrun set.

SAVE:
- map_rd_sel=cnt; shadow[cnt] <= map_reg_data each clock; dirty[cnt] cleared.
- Exits after cnt=3 (exactly 4 cycles) -> IDLE; save_done pulses the cycle after the last capture.
- mapper_busy is ignored (read path only).

RESTORE:
- user_load=1, user_load_sel=cnt, user_load_data=shadow[cnt] only while mapper_busy=0.
- A byte is accepted on a clock edge with user_load=1; cnt advances only on accept.
- While mapper_busy=1: user_load=0, cnt holds, indefinitely.
- After byte 3 is accepted -> IDLE; restore_done pulses next cycle; dirty cleared.
- Minimum 4 cycles.

Event rules:
- trap_enter or trap_exit while not IDLE: ignored, overrun <= 1 (sticky).
- busy = (state != IDLE).

CPU window:
- Reads are allowed in any state: addr 0..3 -> shadow[addr]; STATUS_ADDR -> {5'b0, overrun, |dirty, busy}; other addresses -> 0x00.
- Writes in IDLE only: addr 0..3 -> shadow[addr] <= cpu_wdata and dirty[addr] <= 1; write to STATUS_ADDR with bit2=1 clears overrun.
- Writes while busy are dropped; no side effects.
- A CPU write in the same cycle as a trap event in IDLE is performed, then the sequence starts.
- In SAVE, the captured value overwrites any prior write.

Reset mid-sequence: returns to IDLE immediately; no further load strobes; shadows cleared.

Optional Feature:
MAPSTATE_DIRTY_ONLY_EN.
- Defined: RESTORE writes only bytes with dirty[i]=1, in ascending order, skipping clean indices with no cycle spent. If dirty=0, trap_exit produces restore_done on the next cycle with no user_load.
- Undefined: all four bytes are always written; dirty bits serve only as status.

Test Plan:
- Mapper readout returns 0x12,0x34,0x56,0x78 for sel 0..3; pulse trap_enter -> map_rd_sel 0,1,2,3 on consecutive cycles, busy for 4 cycles, save_done pulse, CPU reads addr0..3 = 0x12,0x34,0x56,0x78.
- After save, CPU writes addr2=0xAB, then trap_exit with mapper_busy=0 -> user_load for 4 cycles, sel/data = (0,0x12),(1,0x34),(2,0xAB),(3,0x78), restore_done, status bit1 cleared.
- Restore with mapper_busy high for 3 cycles during byte 1 -> user_load low for those cycles, byte 1 presented again with sel=1 after busy drops, total 7 cycles.
- trap_enter and trap_exit same cycle in IDLE -> SAVE runs, no restore, status=0x05 during save (busy, overrun); write 0x04 to STATUS_ADDR after -> status 0x00.
- CPU write addr1=0xFF during SAVE -> dropped, shadow1 holds captured value; reset asserted in RESTORE cnt=2 -> next cycle user_load=0, busy=0, shadows 0x00.
- With MAPSTATE_DIRTY_ONLY_EN: write only addr3=0x9C after save, trap_exit -> exactly one user_load (sel=3, data=0x9C), then restore_done.
